srpt_grant_scheduler: RTL and testbench

//  Parametrised SRPT grant scheduler for Homa receive side. Pops incoming DATA header summaries from
//  the header FIFO and tracks up to ENTRIES active inbound messages in a table. It issues grant

---
 rtl/srpt_grant_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_srpt_grant_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/srpt_grant_scheduler.sv
// SRPT grant scheduler for the Homa receive path: tracks active inbound messages and
// grants the OVERCOMMIT messages with the fewest remaining bytes, ranked for priority.
module srpt_grant_scheduler #(
    parameter int unsigned ENTRIES     = 16,
    parameter int unsigned OVERCOMMIT  = 4,
    parameter int unsigned RTT_BYTES   = 10000,
    parameter int unsigned PRIO_LEVELS = 8,
    parameter int unsigned PEER_W      = 14,
    parameter int unsigned RPC_W       = 14
) (
    input  logic                                             ap_clk,
    input  logic                                             ap_rst,
    input  logic                                             ap_ce,
    input  logic                                             header_in_empty_i,
    output logic                                             header_in_read_en_o,
    input  logic [PEER_W+RPC_W+96-1:0]                       header_in_data_i,
    input  logic                                             grant_pkt_full_i,
    output logic                                             grant_pkt_write_en_o,
    output logic [PEER_W+RPC_W+32+$clog2(PRIO_LEVELS)-1:0]   grant_pkt_data_o,
    output logic [$clog2(ENTRIES+1)-1:0]                     active_count_o,
    output logic [15:0]                                      drop_count_o,
    output logic                                             ap_idle
);

    localparam int unsigned PRIO_W = $clog2(PRIO_LEVELS);
    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned CNT_W  = $clog2(ENTRIES + 1);
    localparam int unsigned HDR_W  = PEER_W + RPC_W + 96;
    localparam int unsigned GNT_W  = PEER_W + RPC_W + 32 + PRIO_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_UPDATE,
        S_SCAN,
        S_EMIT
    } state_t;

    state_t state_q, state_d;

    logic [HDR_W-1:0]   hdr_q;
    logic [ENTRIES-1:0] valid_q;
    logic [PEER_W-1:0]  peer_q    [ENTRIES];
    logic [RPC_W-1:0]   rpc_q     [ENTRIES];
    logic [31:0]        len_q     [ENTRIES];
    logic [31:0]        recv_q    [ENTRIES];
    logic [31:0]        granted_q [ENTRIES];

    logic               hit_q, free_q;
    logic [IDX_W-1:0]   hit_idx_q, free_idx_q, idx_q;
    logic [15:0]        drop_q;
    logic [GNT_W-1:0]   gnt_q;

    // Latched header fields
    logic [PEER_W-1:0]  hdr_peer;
    logic [RPC_W-1:0]   hdr_rpc;
    logic [31:0]        hdr_len, hdr_inc, hdr_off;

    assign hdr_off  = hdr_q[31:0];
    assign hdr_inc  = hdr_q[63:32];
    assign hdr_len  = hdr_q[95:64];
    assign hdr_rpc  = hdr_q[96 +: RPC_W];
    assign hdr_peer = hdr_q[96+RPC_W +: PEER_W];

    // Parallel rpc match and lowest free slot
    logic             hit_c, free_c;
    logic [IDX_W-1:0] hit_idx_c, free_idx_c;

    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int k = 0; k < int'(ENTRIES); k++) begin
            if (valid_q[k] && (rpc_q[k] == hdr_rpc) && !hit_c) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(k);
            end
            if (!valid_q[k] && !free_c) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(k);
            end
        end
    end

    // Received offset after a hit: monotonic and never past the stored length
    logic [31:0] upd_recv_c;

    always_comb begin
        upd_recv_c = recv_q[hit_idx_q];
        if (hdr_off > upd_recv_c)
            upd_recv_c = hdr_off;
        if (upd_recv_c > len_q[hit_idx_q])
            upd_recv_c = len_q[hit_idx_q];
    end

    // SRPT rank of the scanned entry; ties broken by lower index
    logic [31:0]       rem_c [ENTRIES];
    logic [CNT_W-1:0]  rank_c;
    logic [32:0]       sum_c;
    logic [31:0]       new_off_c;
    logic [PRIO_W-1:0] prio_c;
    logic              eligible_c;

    always_comb begin
        for (int k = 0; k < int'(ENTRIES); k++)
            rem_c[k] = len_q[k] - recv_q[k];
        rank_c = '0;
        for (int k = 0; k < int'(ENTRIES); k++) begin
            if (valid_q[k] && ((rem_c[k] < rem_c[idx_q]) ||
                               ((rem_c[k] == rem_c[idx_q]) && (k < int'(idx_q)))))
                rank_c = rank_c + CNT_W'(1);
        end
        sum_c      = {1'b0, recv_q[idx_q]} + 33'(RTT_BYTES);
        new_off_c  = (sum_c > {1'b0, len_q[idx_q]}) ? len_q[idx_q] : sum_c[31:0];
        prio_c     = (32'(rank_c) > (PRIO_LEVELS - 1)) ? PRIO_W'(PRIO_LEVELS - 1) : PRIO_W'(rank_c);
        eligible_c = valid_q[idx_q] && (rank_c < CNT_W'(OVERCOMMIT)) &&
                     (new_off_c > granted_q[idx_q]);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            state_q <= S_IDLE;
        else if (ap_ce)
            state_q <= state_d;
    end

    always_comb begin
        state_d              = state_q;
        header_in_read_en_o  = 1'b0;
        grant_pkt_write_en_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_ce && !ap_rst && !header_in_empty_i) begin
                    header_in_read_en_o = 1'b1;
                    state_d             = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_UPDATE;
            S_UPDATE: state_d = S_SCAN;
            S_SCAN: begin
                if (eligible_c)
                    state_d = S_EMIT;
                else if (idx_q == IDX_W'(ENTRIES - 1))
                    state_d = S_IDLE;
            end
            S_EMIT: begin
                if (!grant_pkt_full_i) begin
                    grant_pkt_write_en_o = ap_ce;
                    state_d = (idx_q == IDX_W'(ENTRIES - 1)) ? S_IDLE : S_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Table, header latch, scan pointer and counters
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            hdr_q      <= '0;
            valid_q    <= '0;
            hit_q      <= 1'b0;
            free_q     <= 1'b0;
            hit_idx_q  <= '0;
            free_idx_q <= '0;
            idx_q      <= '0;
            drop_q     <= '0;
            gnt_q      <= '0;
            for (int k = 0; k < int'(ENTRIES); k++) begin
                peer_q[k]    <= '0;
                rpc_q[k]     <= '0;
                len_q[k]     <= '0;
                recv_q[k]    <= '0;
                granted_q[k] <= '0;
            end
        end else if (ap_ce) begin
            case (state_q)
                S_IDLE: begin
                    if (!header_in_empty_i)
                        hdr_q <= header_in_data_i;
                end
                S_LOOKUP: begin
                    hit_q      <= hit_c;
                    hit_idx_q  <= hit_idx_c;
                    free_q     <= free_c;
                    free_idx_q <= free_idx_c;
                end
                S_UPDATE: begin
                    idx_q <= '0;
                    if (hit_q) begin
                        recv_q[hit_idx_q] <= upd_recv_c;
                        if (upd_recv_c >= len_q[hit_idx_q])
                            valid_q[hit_idx_q] <= 1'b0;
                    end else if (hdr_off < hdr_len) begin
                        if (free_q) begin
                            valid_q[free_idx_q]   <= 1'b1;
                            peer_q[free_idx_q]    <= hdr_peer;
                            rpc_q[free_idx_q]     <= hdr_rpc;
                            len_q[free_idx_q]     <= hdr_len;
                            recv_q[free_idx_q]    <= hdr_off;
                            granted_q[free_idx_q] <= (hdr_inc > hdr_off) ? hdr_inc : hdr_off;
                        end else if (drop_q != 16'hFFFF) begin
                            drop_q <= drop_q + 16'd1;
                        end
                    end
                end
                S_SCAN: begin
                    if (eligible_c)
                        gnt_q <= {peer_q[idx_q], rpc_q[idx_q], new_off_c, prio_c};
                    else
                        idx_q <= idx_q + IDX_W'(1);
                end
                S_EMIT: begin
                    if (!grant_pkt_full_i) begin
                        granted_q[idx_q] <= gnt_q[PRIO_W +: 32];
                        idx_q            <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    logic [CNT_W-1:0] active_c;

    always_comb begin
        active_c = '0;
        for (int k = 0; k < int'(ENTRIES); k++)
            if (valid_q[k])
                active_c = active_c + CNT_W'(1);
    end

    assign active_count_o   = active_c;
    assign drop_count_o     = drop_q;
    assign grant_pkt_data_o = gnt_q;
    assign ap_idle          = (state_q == S_IDLE);

endmodule

// File: tb/tb_srpt_grant_scheduler.sv
// Directed bench for srpt_grant_scheduler (ENTRIES=4, OVERCOMMIT=2, RTT_BYTES=1000).
module tb_srpt_grant_scheduler;

    localparam int unsigned PEER_W = 14;
    localparam int unsigned RPC_W  = 14;
    localparam int unsigned PRIO_W = 3;
    localparam int unsigned HDR_W  = PEER_W + RPC_W + 96;
    localparam int unsigned GNT_W  = PEER_W + RPC_W + 32 + PRIO_W;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic             ap_ce;
    logic             header_in_empty_i;
    logic             header_in_read_en_o;
    logic [HDR_W-1:0] header_in_data_i;
    logic             grant_pkt_full_i;
    logic             grant_pkt_write_en_o;
    logic [GNT_W-1:0] grant_pkt_data_o;
    logic [2:0]       active_count_o;
    logic [15:0]      drop_count_o;
    logic             ap_idle;

    int checks   = 0;
    int failures = 0;
    logic [GNT_W-1:0] grants[$];

    srpt_grant_scheduler #(
        .ENTRIES(4), .OVERCOMMIT(2), .RTT_BYTES(1000),
        .PRIO_LEVELS(8), .PEER_W(PEER_W), .RPC_W(RPC_W)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .ap_ce(ap_ce),
        .header_in_empty_i(header_in_empty_i),
        .header_in_read_en_o(header_in_read_en_o),
        .header_in_data_i(header_in_data_i),
        .grant_pkt_full_i(grant_pkt_full_i),
        .grant_pkt_write_en_o(grant_pkt_write_en_o),
        .grant_pkt_data_o(grant_pkt_data_o),
        .active_count_o(active_count_o),
        .drop_count_o(drop_count_o),
        .ap_idle(ap_idle)
    );

    always #5 ap_clk = ~ap_clk;

    // Grant FIFO model: every pushed word, captured mid-cycle
    always @(negedge ap_clk)
        if (grant_pkt_write_en_o === 1'b1)
            grants.push_back(grant_pkt_data_o);

    function automatic logic [GNT_W-1:0] gnt(int peer, int rpc, int off, int prio);
        return {14'(peer), 14'(rpc), 32'(off), 3'(prio)};
    endfunction

    function automatic logic [HDR_W-1:0] hdr(int peer, int rpc, int len, int inc, int off);
        return {14'(peer), 14'(rpc), 32'(len), 32'(inc), 32'(off)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge ap_clk); #1;
        ap_rst = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        grants.delete();
    endtask

    task automatic wait_pop();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge ap_clk);
            if (header_in_read_en_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("pop_seen", 64'(ok), 64'd1);
    endtask

    task automatic send(input int peer, input int rpc, input int len, input int inc, input int off);
        @(posedge ap_clk); #1;
        header_in_data_i  = hdr(peer, rpc, len, inc, off);
        header_in_empty_i = 1'b0;
        wait_pop();
        @(posedge ap_clk); #1;
        header_in_empty_i = 1'b1;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge ap_clk);
            if (ap_idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", 64'(ok), 64'd1);
    endtask

    initial begin
        ap_rst            = 1'b1;
        ap_ce             = 1'b1;
        header_in_empty_i = 1'b1;
        header_in_data_i  = '0;
        grant_pkt_full_i  = 1'b0;

        // Power-on reset values
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_read_en", 64'(header_in_read_en_o), 64'd0);
        check("rst_write_en", 64'(grant_pkt_write_en_o), 64'd0);
        check("rst_active", 64'(active_count_o), 64'd0);
        check("rst_drop", 64'(drop_count_o), 64'd0);
        check("rst_idle", 64'(ap_idle), 64'd1);
        check("rst_gnt_data", 64'(grant_pkt_data_o), 64'd0);
        @(posedge ap_clk); #1 ap_rst = 1'b0;

        // Async reset in the middle of a scan, with another header waiting
        send(9, 9, 5000, 0, 100);
        repeat (3) @(negedge ap_clk);
        check("mid_active_before", 64'(active_count_o), 64'd1);
        header_in_data_i  = hdr(8, 8, 5000, 0, 100);
        header_in_empty_i = 1'b0;
        #2 ap_rst = 1'b1;
        #1;
        check("mid_rst_read_en", 64'(header_in_read_en_o), 64'd0);
        check("mid_rst_write_en", 64'(grant_pkt_write_en_o), 64'd0);
        check("mid_rst_active", 64'(active_count_o), 64'd0);
        check("mid_rst_drop", 64'(drop_count_o), 64'd0);
        check("mid_rst_idle", 64'(ap_idle), 64'd1);
        check("mid_rst_gnt_data", 64'(grant_pkt_data_o), 64'd0);
        repeat (3) @(posedge ap_clk);
        #1;
        header_in_empty_i = 1'b1;
        ap_rst            = 1'b0;
        grants.delete();

        // Clock enable low blocks the pop
        @(posedge ap_clk); #1;
        ap_ce             = 1'b0;
        header_in_data_i  = hdr(30, 30, 5000, 0, 100);
        header_in_empty_i = 1'b0;
        repeat (2) @(negedge ap_clk);
        check("ce_low_read_en", 64'(header_in_read_en_o), 64'd0);
        check("ce_low_idle", 64'(ap_idle), 64'd1);
        @(posedge ap_clk); #1;
        header_in_empty_i = 1'b1;
        ap_ce             = 1'b1;

        // Single message, then a fully unscheduled one
        send(1, 1, 5000, 1000, 500);
        wait_idle();
        check("single_ngrants", 64'(grants.size()), 64'd1);
        check("single_grant", 64'(grants[0]), 64'(gnt(1, 1, 1500, 0)));
        check("single_active", 64'(active_count_o), 64'd1);
        grants.delete();
        send(1, 5, 1200, 0, 1200);
        wait_idle();
        check("unsched_ngrants", 64'(grants.size()), 64'd0);
        check("unsched_active", 64'(active_count_o), 64'd1);

        // SRPT ordering among three messages
        do_reset();
        send(2, 2, 3000, 100, 100);
        wait_idle();
        check("srpt_rpc2_ngrants", 64'(grants.size()), 64'd1);
        check("srpt_rpc2_grant", 64'(grants[0]), 64'(gnt(2, 2, 1100, 0)));
        grants.delete();
        send(1, 1, 5000, 100, 100);
        wait_idle();
        check("srpt_rpc1_ngrants", 64'(grants.size()), 64'd1);
        check("srpt_rpc1_grant", 64'(grants[0]), 64'(gnt(1, 1, 1100, 1)));
        grants.delete();
        send(3, 3, 8000, 100, 100);
        wait_idle();
        check("srpt_rpc3_ngrants", 64'(grants.size()), 64'd0);
        check("srpt_active", 64'(active_count_o), 64'd3);

        // Completion frees rpc2 and promotes rpc3; then a clipped grant
        grants.delete();
        send(2, 2, 3000, 0, 3000);
        wait_idle();
        check("done_active", 64'(active_count_o), 64'd2);
        check("done_ngrants", 64'(grants.size()), 64'd1);
        check("done_grant", 64'(grants[0]), 64'(gnt(3, 3, 1100, 1)));
        grants.delete();
        send(4, 4, 1200, 0, 500);
        wait_idle();
        check("clip_ngrants", 64'(grants.size()), 64'd1);
        check("clip_grant", 64'(grants[0]), 64'(gnt(4, 4, 1200, 0)));
        check("clip_active", 64'(active_count_o), 64'd3);

        // Table overflow
        do_reset();
        for (int r = 10; r < 14; r++) begin
            send(r, r, 20000, 100, 100);
            wait_idle();
        end
        check("ovf_full_active", 64'(active_count_o), 64'd4);
        check("ovf_pre_ngrants", 64'(grants.size()), 64'd2);
        grants.delete();
        send(14, 14, 20000, 100, 100);
        wait_idle();
        check("ovf_drop", 64'(drop_count_o), 64'd1);
        check("ovf_active", 64'(active_count_o), 64'd4);
        check("ovf_ngrants", 64'(grants.size()), 64'd0);

        // Backpressure in EMIT with a second header already waiting
        @(posedge ap_clk); #1;
        grant_pkt_full_i  = 1'b1;
        header_in_data_i  = hdr(10, 10, 20000, 100, 600);
        header_in_empty_i = 1'b0;
        wait_pop();
        @(posedge ap_clk); #1;
        header_in_data_i  = hdr(11, 11, 20000, 100, 600);
        repeat (4) @(negedge ap_clk);
        for (int k = 0; k < 10; k++) begin
            check("bp_write_en", 64'(grant_pkt_write_en_o), 64'd0);
            check("bp_read_en", 64'(header_in_read_en_o), 64'd0);
            check("bp_data", 64'(grant_pkt_data_o), 64'(gnt(10, 10, 1600, 0)));
            check("bp_busy", 64'(ap_idle), 64'd0);
            @(negedge ap_clk);
        end
        @(posedge ap_clk); #1;
        grant_pkt_full_i  = 1'b0;
        header_in_empty_i = 1'b1;
        wait_idle();
        check("bp_release_ngrants", 64'(grants.size()), 64'd1);
        check("bp_release_grant", 64'(grants[0]), 64'(gnt(10, 10, 1600, 0)));
        grants.delete();
        send(11, 11, 20000, 100, 600);
        wait_idle();
        check("bp_next_ngrants", 64'(grants.size()), 64'd1);
        check("bp_next_grant", 64'(grants[0]), 64'(gnt(11, 11, 1600, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
